// File: rtl/axi_pkt_rr_arbiter.sv
// axi_pkt_rr_arbiter
// Packet-granular round-robin arbiter feeding a single AXI-Stream ingress.
// A source keeps the grant until its TLAST beat is accepted, so packets are
// never interleaved. Beats pass through one registered output stage.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   s_tvalid/s_tready   per-source handshake (NUM_PORTS bits)
//   s_tdata             per-source data, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_tlast             per-source end of packet
//   m_tvalid/m_tready   output handshake toward the ingress slave
//   m_tdata/m_tlast     registered output beat
//   m_tid               source index of the current output beat
//   grant               one-hot grant, zero when idle
//   busy                high while a packet is locked
//
// Optional build macro ARB_PKT_STATS_EN adds:
//   pkt_cnt             16-bit per-source count of accepted TLAST beats
//   stats_clr           synchronous clear of all counters (wins over increment)
module axi_pkt_rr_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 512,
    parameter int ID_W       = $clog2(NUM_PORTS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            s_tvalid,
    output logic [NUM_PORTS-1:0]            s_tready,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_PORTS-1:0]            s_tlast,
    output logic                            m_tvalid,
    input  logic                            m_tready,
    output logic [DATA_WIDTH-1:0]           m_tdata,
    output logic                            m_tlast,
    output logic [ID_W-1:0]                 m_tid,
    output logic [NUM_PORTS-1:0]            grant,
    output logic                            busy
`ifdef ARB_PKT_STATS_EN
    ,
    output logic [NUM_PORTS*16-1:0]         pkt_cnt,
    input  logic                            stats_clr
`endif
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                  state_q, state_d;
    logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]         gidx_q, gidx_d;
    logic [NUM_PORTS-1:0]    grant_q, grant_d;
    logic                    m_tvalid_q, m_tvalid_d;
    logic [DATA_WIDTH-1:0]   m_tdata_q, m_tdata_d;
    logic                    m_tlast_q, m_tlast_d;
    logic [ID_W-1:0]         m_tid_q, m_tid_d;

    logic                    out_free;
    logic                    accept;
    logic                    sel_last;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic                    found;
    logic [ID_W-1:0]         win;
    logic [ID_W-1:0]         cand;

    // The output register can take a new beat when empty or draining this cycle.
    assign out_free = !m_tvalid_q || m_tready;
    // grant_q is zero outside LOCKED, so only the granted source sees ready.
    assign s_tready = (state_q == LOCKED && out_free) ? grant_q : '0;
    assign accept   = |(s_tvalid & s_tready);
    assign sel_last = s_tlast[gidx_q];
    assign sel_data = s_tdata[gidx_q*DATA_WIDTH +: DATA_WIDTH];

    // Round-robin search starting just after the last packet's owner.
    // The modulo keeps candidates below NUM_PORTS for non power-of-two counts.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = ID_W'((int'(rr_ptr_q) + k) % NUM_PORTS);
            if (!found && s_tvalid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        gidx_d     = gidx_q;
        grant_d    = grant_q;
        m_tvalid_d = m_tvalid_q;
        m_tdata_d  = m_tdata_q;
        m_tlast_d  = m_tlast_q;
        m_tid_d    = m_tid_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = LOCKED;
                    gidx_d  = win;
                    grant_d = NUM_PORTS'(1) << win;
                end
            end
            LOCKED: begin
                if (accept && sel_last) begin
                    state_d  = IDLE;
                    rr_ptr_d = gidx_q;
                    grant_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Output stage: load on accept, otherwise empty once consumed.
        // Payload holds while the beat is stalled.
        if (accept) begin
            m_tvalid_d = 1'b1;
            m_tdata_d  = sel_data;
            m_tlast_d  = sel_last;
            m_tid_d    = gidx_q;
        end else if (m_tready) begin
            m_tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= ID_W'(NUM_PORTS - 1);
            gidx_q     <= '0;
            grant_q    <= '0;
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            m_tlast_q  <= 1'b0;
            m_tid_q    <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gidx_q     <= gidx_d;
            grant_q    <= grant_d;
            m_tvalid_q <= m_tvalid_d;
            m_tdata_q  <= m_tdata_d;
            m_tlast_q  <= m_tlast_d;
            m_tid_q    <= m_tid_d;
        end
    end

    assign m_tvalid = m_tvalid_q;
    assign m_tdata  = m_tdata_q;
    assign m_tlast  = m_tlast_q;
    assign m_tid    = m_tid_q;
    assign grant    = grant_q;
    assign busy     = (state_q == LOCKED);

`ifdef ARB_PKT_STATS_EN
    logic [NUM_PORTS-1:0][15:0] pkt_cnt_q, pkt_cnt_d;

    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (stats_clr) begin
            pkt_cnt_d = '0;
        end else if (accept && sel_last) begin
            pkt_cnt_d[gidx_q] = pkt_cnt_q[gidx_q] + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign pkt_cnt = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_axi_pkt_rr_arbiter.sv
// Self-checking bench for axi_pkt_rr_arbiter (NUM_PORTS=4, DATA_WIDTH=64).
// Drivers push per-source packets; a negedge monitor keeps a packet-level
// reference (per-source beat queues, last-winner round robin) and compares.
module tb_axi_pkt_rr_arbiter;
    localparam int NP = 4;
    localparam int DW = 64;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP-1:0]     s_tvalid, s_tready, s_tlast, grant;
    logic [NP*DW-1:0]  s_tdata;
    logic              m_tvalid, m_tready, m_tlast, busy;
    logic [DW-1:0]     m_tdata;
    logic [IW-1:0]     m_tid;
`ifdef ARB_PKT_STATS_EN
    logic [NP*16-1:0]  pkt_cnt;
    logic              stats_clr;
`endif

    always #5 clk = ~clk;

    axi_pkt_rr_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
        .m_tid(m_tid), .grant(grant), .busy(busy)
`ifdef ARB_PKT_STATS_EN
        , .pkt_cnt(pkt_cnt), .stats_clr(stats_clr)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- stimulus configuration / driver state ----------------
    int  pkts_left[NP];
    int  len[NP];
    int  beat[NP];
    int  pkt_no[NP];
    bit  active[NP];
    int  start_pct, drop_pct, rdy_pct, fixed_len;
    bit  stall, stats_rand, stats_force;
    logic [NP-1:0] hs;

    initial begin
        s_tvalid = '0; s_tdata = '0; s_tlast = '0; m_tready = 1'b0;
`ifdef ARB_PKT_STATS_EN
        stats_clr = 1'b0;
`endif
        for (int i = 0; i < NP; i++) begin
            pkts_left[i] = 0; len[i] = 1; beat[i] = 0; pkt_no[i] = 0; active[i] = 0;
        end
        forever begin
            @(negedge clk);
            hs = s_tvalid & s_tready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NP; i++) begin
                if (rst) begin
                    active[i] = 0;
                end else if (hs[i]) begin
                    beat[i]++;
                    if (beat[i] == len[i]) begin
                        active[i] = 0;
                        pkt_no[i]++;
                    end
                end
                if (!rst && !active[i] && pkts_left[i] > 0 && $urandom_range(99) < start_pct) begin
                    active[i] = 1;
                    pkts_left[i]--;
                    len[i]  = (fixed_len != 0) ? fixed_len : int'($urandom_range(4, 1));
                    beat[i] = 0;
                end
                s_tvalid[i] = active[i] && ($urandom_range(99) >= drop_pct);
                s_tdata[i*DW +: DW] = {8'(i), 24'(pkt_no[i]), 16'(beat[i]), 16'hC0DE};
                s_tlast[i] = active[i] && (beat[i] == len[i] - 1);
            end
            m_tready = !stall && ($urandom_range(99) >= rdy_pct);
`ifdef ARB_PKT_STATS_EN
            stats_clr = stats_force || (stats_rand && $urandom_range(39) == 0);
`endif
        end
    end

    // ---------------- reference model + monitor ----------------
    logic [DW:0]     exp_q[NP][$];
    int              model_last;
    int              mcnt[NP];
    logic [NP-1:0]   prev_valid, exp_rdy;
    bit              prev_busy, prev_mv, prev_mr, prev_last, prev_acc, prev_acc_last, in_pkt;
    logic [DW-1:0]   prev_data, prev_acc_data;
    logic [IW-1:0]   prev_tid, cur_tid;
    int              prev_acc_src, w;
    bit              fnd, acc, acc_last;
    logic [DW-1:0]   acc_data;
    int              acc_src;
    logic [DW:0]     eb;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_m_tvalid", m_tvalid, 0);
            chk("rst_m_tdata", m_tdata, 0);
            chk("rst_m_tlast", m_tlast, 0);
            chk("rst_m_tid", m_tid, 0);
            chk("rst_grant", grant, 0);
            chk("rst_busy", busy, 0);
            chk("rst_s_tready", s_tready, 0);
`ifdef ARB_PKT_STATS_EN
            chk("rst_pkt_cnt", pkt_cnt, 0);
            for (int i = 0; i < NP; i++) mcnt[i] = 0;
`endif
            for (int i = 0; i < NP; i++) exp_q[i].delete();
            model_last = NP - 1;
            in_pkt = 0; prev_busy = 0; prev_mv = 0; prev_acc = 0;
        end else begin
            // ready only to the owner, and only when the output stage can take a beat
            exp_rdy = busy ? (grant & {NP{(!m_tvalid || m_tready)}}) : '0;
            chk("s_tready", s_tready, exp_rdy);
            chk("grant_count", $countones(grant), busy ? 1 : 0);

            // a request seen during an idle cycle must lock on the next source after the last winner
            if (!prev_busy) begin
                chk("lock_on_req", busy, |prev_valid);
                if (|prev_valid) begin
                    fnd = 0; w = 0;
                    for (int k = 1; k <= NP; k++) begin
                        if (!fnd && prev_valid[(model_last + k) % NP]) begin
                            fnd = 1; w = (model_last + k) % NP;
                        end
                    end
                    chk("rr_winner", grant, 64'(1) << w);
                end
            end

            if (prev_acc) begin
                chk("lat_m_tvalid", m_tvalid, 1);
                chk("lat_m_tdata", m_tdata, prev_acc_data);
                chk("lat_m_tid", m_tid, prev_acc_src);
                if (prev_acc_last) chk("busy_drop", busy, 0);
            end

            if (prev_mv && !prev_mr) begin
                chk("hold_m_tvalid", m_tvalid, 1);
                chk("hold_m_tdata", m_tdata, prev_data);
                chk("hold_m_tlast", m_tlast, prev_last);
                chk("hold_m_tid", m_tid, prev_tid);
            end

            if (m_tvalid && m_tready) begin
                if (in_pkt) chk("no_interleave", m_tid, cur_tid);
                chk("beat_expected", exp_q[m_tid].size() > 0, 1);
                if (exp_q[m_tid].size() > 0) begin
                    eb = exp_q[m_tid].pop_front();
                    chk("out_tdata", m_tdata, eb[DW-1:0]);
                    chk("out_tlast", m_tlast, eb[DW]);
                end
                in_pkt  = !m_tlast;
                cur_tid = m_tid;
            end

            acc = 0; acc_last = 0; acc_data = '0; acc_src = 0;
            for (int i = 0; i < NP; i++) begin
                if (s_tvalid[i] && s_tready[i]) begin
                    acc = 1; acc_src = i;
                    acc_data = s_tdata[i*DW +: DW];
                    acc_last = s_tlast[i];
                    exp_q[i].push_back({s_tlast[i], s_tdata[i*DW +: DW]});
                    if (s_tlast[i]) model_last = i;
                end
            end

`ifdef ARB_PKT_STATS_EN
            for (int i = 0; i < NP; i++) chk("pkt_cnt", pkt_cnt[i*16 +: 16], 16'(mcnt[i]));
            if (stats_clr) begin
                for (int i = 0; i < NP; i++) mcnt[i] = 0;
            end else if (acc && acc_last) begin
                mcnt[acc_src] = (mcnt[acc_src] + 1) & 16'hFFFF;
            end
`endif

            prev_busy = busy; prev_mv = m_tvalid; prev_mr = m_tready;
            prev_data = m_tdata; prev_last = m_tlast; prev_tid = m_tid;
            prev_acc = acc; prev_acc_last = acc_last; prev_acc_data = acc_data; prev_acc_src = acc_src;
        end
        prev_valid = s_tvalid;
    end

    // ---------------- sequencing ----------------
    task automatic drain(input string nm, input int bound);
        bit done;
        done = 0;
        for (int c = 0; c < bound && !done; c++) begin
            @(negedge clk); #3;
            done = !m_tvalid && !busy;
            for (int i = 0; i < NP; i++)
                if (pkts_left[i] != 0 || active[i] || exp_q[i].size() != 0) done = 0;
        end
        chk({nm, "_drained"}, done, 1);
    endtask

    task automatic wait_busy(input string nm, input int bound);
        bit seen;
        seen = 0;
        for (int c = 0; c < bound && !seen; c++) begin
            @(negedge clk); #3;
            seen = busy;
        end
        chk({nm, "_busy_seen"}, seen, 1);
    endtask

    task automatic cfg(input int sp, input int dp, input int rp, input int fl);
        start_pct = sp; drop_pct = dp; rdy_pct = rp; fixed_len = fl;
    endtask

    initial begin
        rst = 1'b1; stall = 0; stats_rand = 0; stats_force = 0;
        cfg(0, 0, 0, 1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;

        // single source, 3-beat packet
        cfg(100, 0, 0, 3);
        pkts_left[0] = 1;
        drain("s0_3beat", 200);

        // all sources, back-to-back single-beat packets
        cfg(100, 0, 0, 1);
        for (int i = 0; i < NP; i++) pkts_left[i] = 2;
        drain("all_1beat", 400);

        // s2 requests while s1 holds a 4-beat packet
        cfg(100, 0, 0, 4);
        pkts_left[1] = 1;
        repeat (4) @(negedge clk);
        #3 pkts_left[2] = 1;
        drain("s1_hold", 400);

        // 5-cycle output stall in the middle of an s0 packet
        cfg(100, 0, 0, 4);
        pkts_left[0] = 1;
        wait_busy("stall", 50);
        repeat (2) @(negedge clk);
        #3 stall = 1;
        repeat (5) @(negedge clk);
        #3 stall = 0;
        drain("stall", 400);

        // randomized traffic with valid gaps and backpressure
        cfg(30, 20, 25, 0);
        stats_rand = 1;
        for (int i = 0; i < NP; i++) pkts_left[i] = 30;
        drain("random", 20000);
        stats_rand = 0;

        // reset in the middle of an s3 packet, then s0 and s3 compete
        cfg(100, 0, 0, 4);
        pkts_left[3] = 1;
        wait_busy("pre_rst", 50);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        #1 pkts_left[0] = 1; pkts_left[3] = 1;
        wait_busy("post_rst", 50);
        chk("post_rst_grant_s0", grant, 4'b0001);
        drain("post_rst", 400);

`ifdef ARB_PKT_STATS_EN
        cfg(100, 0, 0, 2);
        pkts_left[1] = 2; pkts_left[2] = 1;
        drain("stats", 400);
        chk("cnt_s0", pkt_cnt[0 +: 16], 1);
        chk("cnt_s1", pkt_cnt[16 +: 16], 2);
        chk("cnt_s2", pkt_cnt[32 +: 16], 1);
        chk("cnt_s3", pkt_cnt[48 +: 16], 1);
        cfg(100, 0, 0, 1);
        stats_force = 1;
        pkts_left[0] = 1;
        drain("stats_clr", 200);
        stats_force = 0;
        repeat (2) @(negedge clk);
        #3 chk("cnt_cleared", pkt_cnt, 0);
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
